dmem_arbiter: RTL

- Two-port arbiter and access sequencer in front of the data memory.
- Shares the memory between the core load/store path (port 0) and the debug/DMA path (port 1) using round-robin arbitration.
- Converts byte, halfword and word requests into word-aligned memory accesses; sub-word stores use read-modify-write.
- Memory model: combinational read, synchronous write, full-word only, big-endian byte order (byte offset 0 = bits [31:24]).

---
 rtl/dmem_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter and access sequencer.
// Port 0 (core) and port 1 (debug/DMA) share one memory through round-robin
// arbitration. Byte/half/word requests become word-aligned accesses, and
// sub-word stores are done as read-modify-write. Byte order is big-endian,
// so byte offset 0 is bits [31:24].
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid/ready           request handshake, N = 0 (core), 1 (debug/DMA)
//   reqN_addr/we/size/wdata    request payload (size: 00 byte, 01 half, 10 word)
//   reqN_rvalid/rdata/err      one-cycle response, rdata right-aligned
//   mem_addr/we/wdata          word-aligned memory access, synchronous write
//   mem_rdata                  combinational memory read word
module dmem_arbiter #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MEM_BYTES = 16384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_we,
   input  logic [1:0]        req0_size,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_we,
   input  logic [1:0]        req1_size,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   state_e              state_q, state_d;
   logic                prio_q, prio_d;
   logic                id_q, id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   old_q, old_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                any_valid;
   logic                grant_id;
   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_we;
   logic [1:0]          sel_size;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_err;
   logic [4:0]          shamt;
   logic [DATA_W-1:0]   lane_mask;
   logic [DATA_W-1:0]   load_data;
   logic [DATA_W-1:0]   merge_data;

   // Arbitration and payload select
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = prio_q;
      end else begin
         grant_id = req1_valid;
      end
      sel_addr  = grant_id ? req1_addr  : req0_addr;
      sel_we    = grant_id ? req1_we    : req0_we;
      sel_size  = grant_id ? req1_size  : req0_size;
      sel_wdata = grant_id ? req1_wdata : req0_wdata;
      sel_err   = (sel_size == 2'b11) ||
                  ((sel_size == SizeHalf) && sel_addr[0]) ||
                  ((sel_size == SizeWord) && (sel_addr[1:0] != 2'b00)) ||
                  (sel_addr >= ADDR_W'(MEM_BYTES));
   end

   // Lane position within the word: big-endian, so offset k sits (3-k) bytes up
   always_comb begin
      unique case (size_q)
         SizeByte: begin
            shamt     = {~addr_q[1:0], 3'b000};
            lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
         end
         SizeHalf: begin
            shamt     = {~addr_q[1], 4'b0000};
            lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
         end
         default: begin
            shamt     = 5'd0;
            lane_mask = '1;
         end
      endcase
      load_data = (mem_rdata >> shamt) & lane_mask;
      if (size_q == SizeWord) begin
         merge_data = wdata_q;
      end else begin
         merge_data = (old_q & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      id_d    = id_q;
      addr_d  = addr_q;
      we_d    = we_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      old_d   = old_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               id_d    = grant_id;
               addr_d  = sel_addr;
               we_d    = sel_we;
               size_d  = sel_size;
               wdata_d = sel_wdata;
               prio_d  = ~grant_id;
               err_d   = sel_err;
               rdata_d = '0;
               if (sel_err) begin
                  state_d = StResp;
               end else if (!sel_we || (sel_size != SizeWord)) begin
                  state_d = StRead;
               end else begin
                  state_d = StWrite;
               end
            end
         end
         StRead: begin
            old_d = mem_rdata;
            if (we_q) begin
               state_d = StWrite;
            end else begin
               rdata_d = load_data;
               state_d = StResp;
            end
         end
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         prio_q  <= 1'b0;
         id_q    <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         old_q   <= old_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs are forced low while rst is high so an aborted write never lands
   always_comb begin
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      req0_rvalid = 1'b0;
      req1_rvalid = 1'b0;
      req0_rdata  = '0;
      req1_rdata  = '0;
      req0_err    = 1'b0;
      req1_err    = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      if (!rst) begin
         mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
         req0_ready = (state_q == StIdle) && any_valid && !grant_id;
         req1_ready = (state_q == StIdle) && any_valid && grant_id;
         unique case (state_q)
            StWrite: begin
               mem_we    = 1'b1;
               mem_wdata = merge_data;
            end
            StResp: begin
               if (id_q) begin
                  req1_rvalid = 1'b1;
                  req1_rdata  = rdata_q;
                  req1_err    = err_q;
               end else begin
                  req0_rvalid = 1'b1;
                  req0_rdata  = rdata_q;
                  req0_err    = err_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
